// File: rtl/data_memory_responder_pkg.sv
// Shared types for the data-memory responder: state encoding and byte-merge helper.
package data_memory_responder_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MASK_W  = DATA_W / 8;
  localparam int unsigned STATE_W = 2;

  // State encodings are shared with the control-unit stall logic.
  typedef enum logic [STATE_W-1:0] {
    DMR_IDLE    = 2'd0,
    DMR_ACCESS  = 2'd1,
    DMR_RESPOND = 2'd2
  } dmr_state_e;

  // Request payload captured at the accept edge.
  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } dmr_payload_t;

  // Replace only the bytes whose mask bit is set.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [MASK_W-1:0] mask
  );
    logic [DATA_W-1:0] result;
    result = old_word;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (mask[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the core (master) and the data-memory responder (slave).
//   request_valid/request_ready : handshake
//   request_write, address, write_data, write_mask : request payload
//   read_data, read_valid, write_done, busy : completion and status
interface data_memory_responder_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  import data_memory_responder_pkg::*;

  logic                  request_valid;
  logic                  request_ready;
  logic                  request_write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_W-1:0]     write_data;
  logic [MASK_W-1:0]     write_mask;
  logic [DATA_W-1:0]     read_data;
  logic                  read_valid;
  logic                  write_done;
  logic                  busy;

  modport master (
    output request_valid, request_write, address, write_data, write_mask,
    input  request_ready, read_data, read_valid, write_done, busy
  );

  modport slave (
    input  request_valid, request_write, address, write_data, write_mask,
    output request_ready, read_data, read_valid, write_done, busy
  );

endinterface

// File: rtl/data_memory_responder_ram.sv
// Word-addressed RAM with per-byte write enables; synchronous write, combinational read.
//   clk, write_enable, address, write_data, write_mask : write port (shared address)
//   read_data : combinational read of address
module byte_masked_ram
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [MASK_W-1:0]     write_mask,
  output logic [DATA_W-1:0]     read_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (write_enable) mem[address] <= merge_bytes(mem[address], write_data, write_mask);
  end

  assign read_data = mem[address];

endmodule

// File: rtl/data_memory_responder.sv
// Responder for the core's data-memory requests: accepts one request at a time,
// accesses the RAM LATENCY edges after acceptance and pulses write_done/read_valid
// for one cycle.
//   clk, reset (async, active-low)
//   bus : slave side of data_memory_responder_if
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1) begin : g_latency_check
    $fatal(1, "data_memory_responder: LATENCY must be >= 1");
  end

  dmr_state_e            state;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] lat_addr;
  dmr_payload_t          lat_req;
  logic                  request_ready_q;
  logic                  busy_q;
  logic                  read_valid_q;
  logic                  write_done_q;
  logic [DATA_W-1:0]     read_data_q;
  logic [DATA_W-1:0]     ram_rdata_c;
  logic                  ram_we_c;

  // RAM commits only on the access edge of a write.
  assign ram_we_c = (state == DMR_ACCESS) && (count == '0) && lat_req.write;

  byte_masked_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk          (clk),
    .write_enable (ram_we_c),
    .address      (lat_addr),
    .write_data   (lat_req.data),
    .write_mask   (lat_req.mask),
    .read_data    (ram_rdata_c)
  );

  // Request FSM with latency counter; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= DMR_IDLE;
      count           <= '0;
      lat_addr        <= '0;
      lat_req         <= '0;
      request_ready_q <= 1'b1;
      busy_q          <= 1'b0;
      read_valid_q    <= 1'b0;
      write_done_q    <= 1'b0;
      read_data_q     <= '0;
    end else begin
      case (state)
        DMR_IDLE: begin
          // request_ready is high throughout IDLE, so valid alone means accept.
          if (bus.request_valid) begin
            lat_addr        <= bus.address;
            lat_req.write   <= bus.request_write;
            lat_req.data    <= bus.write_data;
            lat_req.mask    <= bus.write_mask;
            count           <= CNT_W'(LATENCY - 1);
            state           <= DMR_ACCESS;
            request_ready_q <= 1'b0;
            busy_q          <= 1'b1;
          end
        end
        DMR_ACCESS: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            state <= DMR_RESPOND;
            if (lat_req.write) begin
              write_done_q <= 1'b1;
            end else begin
              read_valid_q <= 1'b1;
              read_data_q  <= ram_rdata_c;
            end
          end
        end
        DMR_RESPOND: begin
          read_valid_q    <= 1'b0;
          write_done_q    <= 1'b0;
          request_ready_q <= 1'b1;
          busy_q          <= 1'b0;
          state           <= DMR_IDLE;
        end
        default: begin
          read_valid_q    <= 1'b0;
          write_done_q    <= 1'b0;
          request_ready_q <= 1'b1;
          busy_q          <= 1'b0;
          state           <= DMR_IDLE;
        end
      endcase
    end
  end

  assign bus.request_ready = request_ready_q;
  assign bus.busy          = busy_q;
  assign bus.read_valid    = read_valid_q;
  assign bus.write_done    = write_done_q;
  assign bus.read_data     = read_data_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: lane 0 is a LATENCY=2 build, lane 1 a LATENCY=1 build.
// A cycle-indexed transaction model predicts every output; a negedge process compares.
module tb_data_memory_responder;

  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_memory_responder_if #(.ADDR_WIDTH(AW)) bus0 ();
  data_memory_responder_if #(.ADDR_WIDTH(AW)) bus1 ();

  data_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  data_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Stimulus per lane
  logic          t_valid [2];
  logic          t_write [2];
  logic [AW-1:0] t_addr  [2];
  logic [31:0]   t_data  [2];
  logic [3:0]    t_mask  [2];

  assign bus0.request_valid = t_valid[0];
  assign bus0.request_write = t_write[0];
  assign bus0.address       = t_addr[0];
  assign bus0.write_data    = t_data[0];
  assign bus0.write_mask    = t_mask[0];
  assign bus1.request_valid = t_valid[1];
  assign bus1.request_write = t_write[1];
  assign bus1.address       = t_addr[1];
  assign bus1.write_data    = t_data[1];
  assign bus1.write_mask    = t_mask[1];

  logic        o_ready [2];
  logic        o_busy  [2];
  logic        o_rv    [2];
  logic        o_wd    [2];
  logic [31:0] o_rd    [2];

  assign o_ready[0] = bus0.request_ready;
  assign o_busy[0]  = bus0.busy;
  assign o_rv[0]    = bus0.read_valid;
  assign o_wd[0]    = bus0.write_done;
  assign o_rd[0]    = bus0.read_data;
  assign o_ready[1] = bus1.request_ready;
  assign o_busy[1]  = bus1.busy;
  assign o_rv[1]    = bus1.read_valid;
  assign o_wd[1]    = bus1.write_done;
  assign o_rd[1]    = bus1.read_data;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int l);
    return (l == 0) ? 2 : 1;
  endfunction

  // ---------------- transaction model ----------------
  int          cyc = 0;
  logic        m_pend [2];
  logic        m_resp [2];
  logic        m_acc_now [2];
  int          m_acc_cyc [2];
  logic        m_write [2];
  logic [AW-1:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_mask [2];
  logic        m_ready [2];
  logic        m_busy [2];
  logic        m_rv [2];
  logic        m_wd [2];
  logic [31:0] m_rd [2];
  logic [31:0] m_mem [2][1024];

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int l = 0; l < 2; l++) begin
        m_pend[l] = 1'b0; m_resp[l] = 1'b0; m_acc_now[l] = 1'b0;
        m_ready[l] = 1'b1; m_busy[l] = 1'b0; m_rv[l] = 1'b0; m_wd[l] = 1'b0;
        m_rd[l] = 32'h0;
      end
    end else begin
      cyc++;
      for (int l = 0; l < 2; l++) begin
        logic accept;
        accept = t_valid[l] && m_ready[l];
        m_rv[l] = 1'b0; m_wd[l] = 1'b0; m_acc_now[l] = 1'b0; m_resp[l] = 1'b0;
        if (m_pend[l] && cyc == m_acc_cyc[l] + lat(l)) begin
          if (m_write[l]) begin
            for (int b = 0; b < 4; b++)
              if (m_mask[l][b]) m_mem[l][m_addr[l]][8*b +: 8] = m_data[l][8*b +: 8];
            m_wd[l] = 1'b1;
          end else begin
            m_rd[l] = m_mem[l][m_addr[l]];
            m_rv[l] = 1'b1;
          end
          m_pend[l] = 1'b0;
          m_resp[l] = 1'b1;
        end else if (accept) begin
          m_write[l] = t_write[l]; m_addr[l] = t_addr[l];
          m_data[l] = t_data[l];   m_mask[l] = t_mask[l];
          m_pend[l] = 1'b1; m_acc_cyc[l] = cyc; m_acc_now[l] = 1'b1;
        end
        m_busy[l]  = m_pend[l] || m_resp[l];
        m_ready[l] = !m_busy[l];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int          pulse_cyc [2];
  int          n_wd0 = 0;
  logic [31:0] rv_log [$];

  initial forever begin
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("ready_l%0d", l), 32'(o_ready[l]), 32'(m_ready[l]));
      chk($sformatf("busy_l%0d", l),  32'(o_busy[l]),  32'(m_busy[l]));
      chk($sformatf("rvalid_l%0d", l), 32'(o_rv[l]),   32'(m_rv[l]));
      chk($sformatf("wdone_l%0d", l), 32'(o_wd[l]),    32'(m_wd[l]));
      chk($sformatf("rdata_l%0d", l), o_rd[l],         m_rd[l]);
      chk($sformatf("excl_l%0d", l),  32'(o_rv[l] & o_wd[l]), 32'h0);
      if (o_rv[l] || o_wd[l]) pulse_cyc[l] = cyc;
    end
    if (o_wd[0]) n_wd0++;
    if (o_rv[0]) rv_log.push_back(o_rd[0]);
  end

  // ---------------- stimulus helpers ----------------
  // Called at negedge+1; returns at negedge+1 after the accept edge.
  task automatic send(input int l, input logic w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] m);
    bit got;
    got = 1'b0;
    t_write[l] = w; t_addr[l] = a; t_data[l] = d; t_mask[l] = m; t_valid[l] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_acc_now[l]) begin got = 1'b1; break; end
    end
    #1;
    t_valid[l] = 1'b0;
    t_addr[l] = ~a; t_data[l] = ~d; t_mask[l] = ~m;
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_idle(input int l);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_ready[l]) begin got = 1'b1; break; end
    end
    #1;
    if (!got) chk("idle_timeout", 32'h0, 32'h1);
  endtask

  task automatic do_req(input int l, input logic w, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    send(l, w, a, d, m);
    wait_idle(l);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wd_before;
    bit got;
    for (int l = 0; l < 2; l++) begin
      t_valid[l] = 1'b0; t_write[l] = 1'b0; t_addr[l] = '0; t_data[l] = '0; t_mask[l] = '0;
    end
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(o_ready[0]), 32'h1);
    chk("rst_busy",  32'(o_busy[0]),  32'h0);
    chk("rst_rdata", o_rd[0],         32'h0);
    #1 reset = 1'b1;

    // Full write, then masked byte-lane update
    do_req(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    chk("wr_latency", 32'(pulse_cyc[0] - m_acc_cyc[0]), 32'd2);
    do_req(0, 1'b1, 10'd5, 32'h00AA0000, 4'b0100);
    do_req(0, 1'b0, 10'd5, 32'h0, 4'h0);
    chk("masked_read", o_rd[0], 32'hDEAABEEF);
    chk("rd_latency", 32'(pulse_cyc[0] - m_acc_cyc[0]), 32'd2);

    // Zero mask leaves RAM alone but still completes
    do_req(0, 1'b1, 10'd7, 32'h12345678, 4'hF);
    wd_before = n_wd0;
    do_req(0, 1'b1, 10'd7, 32'hFFFFFFFF, 4'h0);
    chk("mask0_done", 32'(n_wd0 - wd_before), 32'd1);
    do_req(0, 1'b0, 10'd7, 32'h0, 4'h0);
    chk("mask0_read", o_rd[0], 32'h12345678);

    // Request held across busy; address change during ACCESS is ignored
    do_req(0, 1'b1, 10'd1, 32'h11, 4'hF);
    do_req(0, 1'b1, 10'd2, 32'h22, 4'hF);
    rv_log.delete();
    t_write[0] = 1'b0; t_addr[0] = 10'd1; t_valid[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_acc_now[0]) begin got = 1'b1; break; end
    end
    if (!got) chk("held_acc1_timeout", 32'h0, 32'h1);
    #1 t_addr[0] = 10'd2;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_acc_now[0]) begin got = 1'b1; break; end
    end
    if (!got) chk("held_acc2_timeout", 32'h0, 32'h1);
    #1 t_valid[0] = 1'b0;
    wait_idle(0);
    chk("held_count", 32'(rv_log.size()), 32'd2);
    if (rv_log.size() == 2) begin
      chk("held_first",  rv_log[0], 32'h11);
      chk("held_second", rv_log[1], 32'h22);
    end

    // Reset during ACCESS discards the write
    do_req(0, 1'b1, 10'd3, 32'h0, 4'hF);
    wd_before = n_wd0;
    send(0, 1'b1, 10'd3, 32'hCAFEF00D, 4'hF);
    reset = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_no_done", 32'(n_wd0 - wd_before), 32'd0);
    do_req(0, 1'b0, 10'd3, 32'h0, 4'h0);
    chk("rst_mem_kept", o_rd[0], 32'h0);

    // LATENCY=1 lane
    do_req(1, 1'b1, 10'd9, 32'hA5A5A5A5, 4'hF);
    do_req(1, 1'b0, 10'd9, 32'h0, 4'h0);
    chk("l1_latency", 32'(pulse_cyc[1] - m_acc_cyc[1]), 32'd1);
    chk("l1_read", o_rd[1], 32'hA5A5A5A5);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
